// File: rtl/sorting_hat_sequencer_pkg.sv
// Shared constants for the sorting-hat sequencer: house indices, FSM encoding,
// LFSR feedback mask and the house one-hot decode.
package sorting_hat_pkg;

  localparam int unsigned HOUSE_W = 2;
  localparam int unsigned LFSR_W  = 16;

  // Palette indices of the four houses
  localparam logic [HOUSE_W-1:0] SLYTHERIN  = 2'd0;
  localparam logic [HOUSE_W-1:0] GRYFFINDOR = 2'd1;
  localparam logic [HOUSE_W-1:0] HUFFLEPUFF = 2'd2;
  localparam logic [HOUSE_W-1:0] RAVENCLAW  = 2'd3;

  // Sequencer states
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SPIN   = 2'd1;
  localparam logic [1:0] ST_SETTLE = 2'd2;
  localparam logic [1:0] ST_HOLD   = 2'd3;

  // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form)
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  // House index to one-hot select vector, bit n = palette index n
  function automatic logic [3:0] house_onehot(input logic [HOUSE_W-1:0] h);
    house_onehot = 4'b0001 << h;
  endfunction

endpackage

// File: rtl/sorting_hat_sequencer_if.sv
// Key/display-side signal bundle of the sorting-hat sequencer.
// Optional force-house inputs exist only when FORCE_HOUSE_EN is defined.
interface sorting_hat_sequencer_if;
  import sorting_hat_pkg::*;

  logic               i_vs;
  logic               i_start;
  logic               i_clr;
`ifdef FORCE_HOUSE_EN
  logic               i_force_vld;
  logic [HOUSE_W-1:0] i_force_house;
`endif
  logic               o_slytherin;
  logic               o_gryffindor;
  logic               o_hufflepuff;
  logic               o_ravenclaw;
  logic [HOUSE_W-1:0] o_house;
  logic               o_busy;
  logic               o_done;

  // Stimulus side (keys / sync generator)
  modport master (
    output i_vs, output i_start, output i_clr,
`ifdef FORCE_HOUSE_EN
    output i_force_vld, output i_force_house,
`endif
    input o_slytherin, input o_gryffindor, input o_hufflepuff, input o_ravenclaw,
    input o_house, input o_busy, input o_done
  );

  // Sequencer side
  modport slave (
    input i_vs, input i_start, input i_clr,
`ifdef FORCE_HOUSE_EN
    input i_force_vld, input i_force_house,
`endif
    output o_slytherin, output o_gryffindor, output o_hufflepuff, output o_ravenclaw,
    output o_house, output o_busy, output o_done
  );

endinterface

// File: rtl/sorting_hat_sequencer_lfsr16.sv
// Free-running 16-bit Galois LFSR; a nonzero seed keeps it out of the all-zero state.
module lfsr16
  import sorting_hat_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              i_rst,
  output logic [LFSR_W-1:0] q
);

  logic [LFSR_W-1:0] q_next;

  // Shift right, fold the tap mask in when a one falls out
  assign q_next = (q >> 1) ^ (q[0] ? LFSR_TAPS : '0);

  // Advance every clock, reload the seed on reset
  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) q <= SEED;
    else        q <= q_next;
  end

endmodule

// File: rtl/sorting_hat_sequencer.sv
// Sorting-hat animation sequencer: spins the house select with a per-step
// growing frame dwell, then settles on a pseudo-random house and holds it.
// Optional macro FORCE_HOUSE_EN adds i_force_vld/i_force_house to override the target.
module sorting_hat_sequencer
  import sorting_hat_pkg::*;
#(
  parameter int unsigned       FRAMES_INIT = 2,
  parameter int unsigned       STEPS       = 12,
  parameter logic [LFSR_W-1:0] LFSR_SEED   = 16'hACE1
) (
  input logic                   clk,
  input logic                   i_rst,
  sorting_hat_sequencer_if.slave bus
);

  localparam int unsigned DW = $clog2(FRAMES_INIT + STEPS + 1);
  localparam int unsigned SW = $clog2(STEPS + 1);
  localparam logic [DW-1:0] DWELL_INIT   = DW'(FRAMES_INIT);
  localparam logic [DW-1:0] DWELL_SETTLE = DW'(FRAMES_INIT + STEPS);
  localparam logic [SW-1:0] STEP_LAST    = SW'(STEPS);

  logic [1:0]         state_q, state_d;
  logic [HOUSE_W-1:0] house_q, house_d;
  logic [HOUSE_W-1:0] target_q, target_d;
  logic [DW-1:0]      dwell_q, dwell_d;
  logic [DW-1:0]      frame_q, frame_d;
  logic [SW-1:0]      step_q, step_d;
  logic               vs_q, start_q;
  logic [3:0]         onehot_q;
  logic               busy_q, done_q;

  logic [LFSR_W-1:0]  lfsr_q;
  logic [HOUSE_W-1:0] target_src;
  logic               unused_lfsr;
  logic               frame_tick, start_edge, dwell_done;
  logic [DW-1:0]      frame_inc;
  logic [SW-1:0]      step_inc;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .i_rst (i_rst),
    .q     (lfsr_q)
  );

  // Only the two low LFSR bits pick the house
  assign unused_lfsr = ^lfsr_q[LFSR_W-1:HOUSE_W];

`ifdef FORCE_HOUSE_EN
  assign target_src = bus.i_force_vld ? bus.i_force_house : lfsr_q[HOUSE_W-1:0];
`else
  assign target_src = lfsr_q[HOUSE_W-1:0];
`endif

  assign frame_tick = vs_q & ~bus.i_vs;
  assign start_edge = bus.i_start & ~start_q;
  assign frame_inc  = frame_q + DW'(1);
  assign step_inc   = step_q + SW'(1);
  assign dwell_done = (frame_inc == dwell_q);

  // State and counter registers plus input edge detectors
  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q  <= ST_IDLE;
      house_q  <= SLYTHERIN;
      target_q <= SLYTHERIN;
      dwell_q  <= DWELL_INIT;
      frame_q  <= '0;
      step_q   <= '0;
      vs_q     <= 1'b1;
      start_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      house_q  <= house_d;
      target_q <= target_d;
      dwell_q  <= dwell_d;
      frame_q  <= frame_d;
      step_q   <= step_d;
      vs_q     <= bus.i_vs;
      start_q  <= bus.i_start;
    end
  end

  // Next-state: clear wins, then start / frame-tick handling per state
  always_comb begin
    state_d  = state_q;
    house_d  = house_q;
    target_d = target_q;
    dwell_d  = dwell_q;
    frame_d  = frame_q;
    step_d   = step_q;
    if (bus.i_clr) begin
      state_d  = ST_IDLE;
      house_d  = SLYTHERIN;
      target_d = SLYTHERIN;
      dwell_d  = DWELL_INIT;
      frame_d  = '0;
      step_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_edge) begin
            state_d = ST_SPIN;
            house_d = SLYTHERIN;
            dwell_d = DWELL_INIT;
            frame_d = '0;
            step_d  = '0;
          end
        end
        ST_SPIN: begin
          if (step_q == STEP_LAST) begin
            state_d = (house_q == target_q) ? ST_HOLD : ST_SETTLE;
            dwell_d = DWELL_SETTLE;
            frame_d = '0;
          end else if (frame_tick) begin
            if (dwell_done) begin
              house_d = house_q + HOUSE_W'(1);
              frame_d = '0;
              dwell_d = dwell_q + DW'(1);
              step_d  = step_inc;
              if (step_inc == STEP_LAST) target_d = target_src;
            end else begin
              frame_d = frame_inc;
            end
          end
        end
        ST_SETTLE: begin
          if (house_q == target_q) begin
            state_d = ST_HOLD;
          end else if (frame_tick) begin
            if (dwell_done) begin
              house_d = house_q + HOUSE_W'(1);
              frame_d = '0;
            end else begin
              frame_d = frame_inc;
            end
          end
        end
        ST_HOLD: begin
          if (start_edge) begin
            state_d = ST_SPIN;
            dwell_d = DWELL_INIT;
            frame_d = '0;
            step_d  = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Registered house select and status flags, all low in IDLE
  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      onehot_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      onehot_q <= (state_d == ST_IDLE) ? 4'b0000 : house_onehot(house_d);
      busy_q   <= (state_d == ST_SPIN) || (state_d == ST_SETTLE);
      done_q   <= (state_d == ST_HOLD);
    end
  end

  assign bus.o_slytherin  = onehot_q[SLYTHERIN];
  assign bus.o_gryffindor = onehot_q[GRYFFINDOR];
  assign bus.o_hufflepuff = onehot_q[HUFFLEPUFF];
  assign bus.o_ravenclaw  = onehot_q[RAVENCLAW];
  assign bus.o_house      = house_q;
  assign bus.o_busy       = busy_q;
  assign bus.o_done       = done_q;

endmodule
